// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared up or up/down period counter feeds CHANNELS
// comparators whose percent duties are double-buffered and swapped in at a period boundary.
module pwm_multichannel #(
  parameter int unsigned PERIOD   = 5000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         center_mode,
  input  logic [CHANNELS*DUTY_W-1:0]   duty_in,
  input  logic [CHANNELS-1:0]          duty_wr,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         period_start
);

  localparam int unsigned PW = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    pend_q [CHANNELS];
  logic [CNT_W-1:0]    pend_d [CHANNELS];
  logic [CNT_W-1:0]    act_q  [CHANNELS];
  logic [CNT_W-1:0]    act_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q, ps_d;
  logic                boundary;
  logic [PW-1:0]       duty_ext;
  logic [PW-1:0]       thr_wide;

  // Counter sequencing, boundary detection and per-channel compare
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    pwm_d    = '0;
    ps_d     = 1'b0;
    duty_ext = '0;
    thr_wide = '0;
    boundary = en && (cnt_q == '0) && (dir_q == DIR_UP);

    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else begin
      if (boundary) mode_d = center_mode;
      ps_d = boundary;
      if (dir_q == DIR_UP) begin
        if (cnt_q == CNT_LAST) begin
          if (mode_q) dir_d = DIR_DOWN;
          else        cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Turn-around at zero repeats the value; the next cycle is the boundary
        if (cnt_q == '0) dir_d = DIR_UP;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      duty_ext = PW'(duty_in[i*DUTY_W +: DUTY_W]);
      if (duty_ext > PW'(100)) duty_ext = PW'(100);
      thr_wide  = (PW'(PERIOD) * duty_ext) / PW'(100);
      pend_d[i] = duty_wr[i] ? CNT_W'(thr_wide) : pend_q[i];
      act_d[i]  = boundary ? pend_q[i] : act_q[i];
      // New threshold already governs the boundary cycle, so no glitch at 100%
      pwm_d[i]  = en && (cnt_q < act_d[i]);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= 1'b0;
      pwm_q  <= '0;
      ps_q   <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel at PERIOD=10, four channels.
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        center_mode;
  logic [31:0] duty_in;
  logic [3:0]  duty_wr;
  logic [3:0]  pwm_out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  pwm_multichannel #(.PERIOD(10), .CNT_W(16), .CHANNELS(4), .DUTY_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .center_mode(center_mode),
    .duty_in(duty_in), .duty_wr(duty_wr),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until period_start is seen (at least one cycle first)
  task automatic wait_ps(input int budget, output logic ok);
    int n = 0;
    step();
    while (period_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    ok = (period_start === 1'b1);
  endtask

  // Sample n cycles from the current one; optionally write ch0 at index wr_k
  task automatic run_period(input int n, input int wr_k, input logic [7:0] wr_val,
                            output int h0, output int h1, output int h2, output int h3,
                            output int psc, output logic ps_end);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; psc = 0;
    for (int k = 0; k < n; k++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      h3 += int'(pwm_out[3]);
      psc += int'(period_start);
      if (k == wr_k) begin
        duty_in[7:0] = wr_val;
        duty_wr      = 4'b0001;
      end else begin
        duty_wr = 4'b0000;
      end
      step();
    end
    duty_wr = 4'b0000;
    ps_end  = period_start;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; center_mode = 1'b0; duty_in = '0; duty_wr = '0;
    step(); step();
    checks++;
    if (pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm got %b want 0000", pwm_out); end
    checks++;
    if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", period_start); end
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int h0, h1, h2, h3, psc;
    logic pe, ok;
    en = 1'b1;
    duty_in = {8'd150, 8'd100, 8'd0, 8'd50};
    duty_wr = 4'b1111;
    step();
    duty_wr = 4'b0000;
    wait_ps(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_wait_ps got timeout want pulse"); end
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 5)  begin errors++; $display("FAIL basic_ch0_high got %0d want 5", h0); end
    checks++; if (h1 != 0)  begin errors++; $display("FAIL basic_ch1_high got %0d want 0", h1); end
    checks++; if (h2 != 10) begin errors++; $display("FAIL basic_ch2_high got %0d want 10", h2); end
    checks++; if (h3 != 10) begin errors++; $display("FAIL basic_ch3_sat got %0d want 10", h3); end
    checks++; if (psc != 1) begin errors++; $display("FAIL basic_ps_count got %0d want 1", psc); end
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL basic_ps_period got %b want 1", pe); end
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++;
    if (h0 != 5 || h2 != 10 || pe !== 1'b1) begin
      errors++; $display("FAIL basic_second_period got h0=%0d h2=%0d ps=%b want 5 10 1", h0, h2, pe);
    end
  endtask

  task automatic test_midwrite();
    int h0, h1, h2, h3, psc;
    logic pe;
    run_period(10, 0, 8'd30, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 5) begin errors++; $display("FAIL mw_pre got %0d want 5", h0); end
    run_period(10, 3, 8'd70, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 3) begin errors++; $display("FAIL mw_current got %0d want 3", h0); end
    run_period(10, 9, 8'd20, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 7) begin errors++; $display("FAIL mw_next got %0d want 7", h0); end
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL mw_ps_end got %b want 1", pe); end
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 7) begin errors++; $display("FAIL mw_boundary_delay got %0d want 7", h0); end
    run_period(10, 2, 8'd30, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 2) begin errors++; $display("FAIL mw_boundary_take got %0d want 2", h0); end
  endtask

  task automatic test_center_mode();
    int h0, h1, h2, h3, psc;
    logic pe;
    center_mode = 1'b1;
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++;
    if (h0 != 3 || psc != 1 || pe !== 1'b1) begin
      errors++; $display("FAIL cm_switch_period got h0=%0d ps=%0d end=%b want 3 1 1", h0, psc, pe);
    end
    run_period(20, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++; if (h0 != 6)  begin errors++; $display("FAIL cm_high got %0d want 6", h0); end
    checks++; if (psc != 1) begin errors++; $display("FAIL cm_ps_count got %0d want 1", psc); end
    checks++; if (pe !== 1'b1) begin errors++; $display("FAIL cm_ps_20 got %b want 1", pe); end
    center_mode = 1'b0;
    run_period(20, 1, 8'd50, h0, h1, h2, h3, psc, pe);
    checks++;
    if (h0 != 6 || psc != 1 || pe !== 1'b1) begin
      errors++; $display("FAIL cm_back_period got h0=%0d ps=%0d end=%b want 6 1 1", h0, psc, pe);
    end
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++;
    if (h0 != 5 || pe !== 1'b1) begin
      errors++; $display("FAIL cm_edge_again got h0=%0d end=%b want 5 1", h0, pe);
    end
  endtask

  task automatic test_enable();
    int h0, h1, h2, h3, psc;
    logic pe;
    int bad;
    step(); step();
    en = 1'b0;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (pwm_out !== 4'b0000 || period_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_off_quiet got %0d bad cycles want 0", bad); end
    en = 1'b1;
    step();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL en_rise_ps got %b want 1", period_start); end
    checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL en_rise_pwm got %b want 1", pwm_out[0]); end
    run_period(10, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++;
    if (h0 != 5 || psc != 1 || pe !== 1'b1) begin
      errors++; $display("FAIL en_resume got h0=%0d ps=%0d end=%b want 5 1 1", h0, psc, pe);
    end
  endtask

  task automatic test_async_reset();
    int h0, h1, h2, h3, psc;
    logic pe;
    checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL ar_pre_high got %b want 1", pwm_out[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL ar_immediate got %b want 0000", pwm_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL ar_ps got %b want 0", period_start); end
    step();
    #2 rst = 1'b0;
    run_period(25, -1, 8'd0, h0, h1, h2, h3, psc, pe);
    checks++;
    if ((h0 + h1 + h2 + h3) != 0) begin
      errors++; $display("FAIL ar_cleared got %0d high cycles want 0", h0 + h1 + h2 + h3);
    end
    checks++; if (psc != 3) begin errors++; $display("FAIL ar_ps_count got %0d want 3", psc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midwrite();
    test_center_mode();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
Multi-channel PWM generator and the parametrised successor to the single-channel PWM clock divider.
- One shared period counter drives CHANNELS independent duty-cycle comparators.
- Duty is given in percent and is double-buffered, so new values take effect only at a period boundary.
- Supports edge-aligned and center-aligned modes, used for motor, LED and servo drive in the FPGA lab design.

Parameters:
- PERIOD, 5000, clock cycles per edge-aligned PWM period (≥2)
- CNT_W, 16, counter width; must satisfy 2^CNT_W > PERIOD
- CHANNELS, 4, number of PWM outputs (1..16)
- DUTY_W, 8, width of each per-channel duty field (percent, 0..100 meaningful)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary only
- duty_in  in  CHANNELS*DUTY_W  packed duty values; channel i at bits [i*DUTY_W +: DUTY_W]
- duty_wr  in  CHANNELS  per-channel write strobe
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse at each period boundary

Behaviour:
- Reset (async, rst=1): counter=0, direction=up, mode register=0, all pending_thr=0, all active_thr=0, pwm_out=0, period_start=0.
- Threshold calculation on write:
  - When duty_wr[i]=1: d = min(duty_in[i], 100).
  - pending_thr[i] <= floor(PERIOD*d/100).
  - Product computed at CNT_W+7 bits, no overflow.
  - Duty >100 saturates to 100.
- Edge mode:
  - Counter 0,1,..,PERIOD-1, then wraps to 0.
  - Boundary = cycle in which the counter equals 0.
- Center mode:
  - Counter counts up 0..PERIOD-1, then down PERIOD-1..0; each endpoint is held for 2 cycles (value repeated at turn-around).
  - Period = 2*PERIOD cycles.
  - Boundary = first cycle of the up phase with counter 0.
- At boundary (when en=1), all in the same cycle:
  - active_thr[i] <= pending_thr[i] for all i.
  - The mode register loads center_mode.
  - period_start=1.
- period_start is 0 on all other cycles.
- Write coinciding with the boundary cycle: active_thr loads the old pending value; the new value takes effect at the next boundary.
- Output compare:
  - pwm_out[i] <= (counter < active_thr[i]); one-cycle latency from counter to output.
  - High time per period is exactly thr cycles (edge) or 2*thr cycles (center).
  - thr=0 gives constantly low; thr=PERIOD gives constantly high with no glitch at the boundary.
- en=0:
  - Counter forced to 0, direction up.
  - pwm_out=0, period_start=0.
  - Writes to pending_thr still accepted.
- en rising: the first cycle with en=1 is a boundary (counter=0, load, pulse).
- Reset mid-period: outputs drop to 0 immediately (async), and all pending values are lost.

Test Plan (PERIOD=10, CHANNELS=4, DUTY_W=8):
1. Reset, en=1, edge mode, write ch0=50, ch1=0, ch2=100, ch3=150:
   - After the next boundary, ch0 is high for 5 of every 10 cycles.
   - ch1 stays constant 0.
   - ch2 and ch3 stay constant 1.
   - period_start pulses every 10 cycles.
2. Edge mode, ch0=30 running; write ch0=70 at counter=4:
   - The current period still shows 3 high cycles.
   - The next period shows 7.
   - A write issued exactly on the boundary cycle is delayed a full period.
3. center_mode=1, ch0=30:
   - The period becomes 20 cycles.
   - pwm_out[0] is high for 6 cycles, centered on counter-low region (3 at end of down phase + 3 at start of up phase).
   - period_start pulses every 20 cycles.
4. Toggle center_mode mid-period:
   - The mode changes only at the next boundary.
   - The period length switches 10→20 without a short or glitched period.
5. en dropped mid-period with ch0=50:
   - pwm_out=0 and the counter holds at 0.
   - On en=1, period_start pulses on the first enabled cycle and 5-high/5-low resumes immediately.
6. Assert rst asynchronously (between clock edges) during a high pulse:
   - pwm_out goes 0 immediately.
   - After release with en=1 and no writes, all outputs stay 0 (thresholds cleared).
